mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
- Memory stage that consumes the execute stage's result bundle: ALU result used as address, store data, read/write controls, access size and signedness.
- Non-memory ops pass through with one cycle of latency.
- Loads and stores become a single request on the data bus (valid/addr_ok/data_ok handshake). Load data is aligned and extended, and the completed result is handed to writeback.
- Sits between execute and writeback and drives pipeline stall while a bus transaction is outstanding.

Parameters:
- DATA_W, 64, data/address width; only 64 is supported.
- ALIGN_CHECK, 1, when 1 a misaligned access raises misalign and issues no bus request.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  execute bundle valid
- in_ready  out  1  stage can accept a bundle this cycle
- in_addr  in  64  ALU result (effective address or ALU value)
- in_wdata  in  64  store data, right-aligned
- in_memread  in  1  load
- in_memwrite  in  1  store
- in_msize  in  2  0=1B, 1=2B, 2=4B, 3=8B
- in_unsigned  in  1  zero-extend load when 1, sign-extend when 0
- in_regwrite  in  1  passthrough control
- in_memtoreg  in  1  passthrough control
- in_dst  in  5  destination register
- in_pc  in  64  passthrough
- dreq_valid  out  1  bus request valid
- dreq_addr  out  64  bus address, equal to in_addr unmodified
- dreq_size  out  2  equal to in_msize
- dreq_strobe  out  8  byte write enables; 0 for loads
- dreq_data  out  64  lane-shifted store data
- dresp_addr_ok  in  1  request accepted
- dresp_data_ok  in  1  transaction complete
- dresp_data  in  64  raw 64-bit read line
- out_valid  out  1  result valid for writeback
- out_ready  in  1  writeback accepts
- out_result  out  64  extended load data or passed-through in_addr
- out_regwrite, out_memtoreg  out  1 each  registered passthrough
- out_dst  out  5  registered passthrough
- out_pc  out  64  registered passthrough
- misalign  out  1  result carries an alignment fault
- stall  out  1  high while state is REQ or WAIT

Behaviour:
- Reset values: state=IDLE; dreq_valid=0; dreq_strobe=0; dreq_addr=0; dreq_data=0; out_valid=0; misalign=0; all out_* fields 0.
- in_ready = (state==IDLE) or (state==DONE and out_ready).
- A bundle is captured on in_valid & in_ready.
- States: IDLE, REQ, WAIT, DONE.
- Capture of a non-memory op, or a misaligned op with ALIGN_CHECK=1: go to DONE next cycle, out_valid=1. out_result=in_addr. misalign set only for the fault case, with out_regwrite forced to 0.
- Capture of a load or store: go to REQ, dreq_valid=1 next cycle. All dreq_* held stable until dresp_addr_ok.
- REQ:
  - addr_ok & data_ok in the same cycle → DONE.
  - addr_ok only → WAIT, dreq_valid drops next cycle.
- WAIT: data_ok → DONE. data_ok is ignored in IDLE and DONE.
- DONE: out_valid=1, outputs held until out_ready.
  - out_ready with no new capture → IDLE.
  - out_ready with a new capture in the same cycle → back-to-back, per the capture rules above.
- Misaligned means in_addr is not a multiple of the access size in bytes. A misaligned op never asserts dreq_valid.
- Store lanes: off=in_addr[2:0]. strobe = ((1<<bytes)-1) << off. dreq_data = in_wdata << (8*off).
- Load extraction: raw = dresp_data >> (8*off), truncated to 8·bytes bits, then zero-extended if in_unsigned, otherwise sign-extended to 64.
- Store completion: out_result=in_addr. out_regwrite follows the captured value.
- Latency:
  - non-memory op: capture at t → out_valid at t+1.
  - memory op with addr_ok and data_ok both in the first REQ cycle: out_valid at t+2.
- Reset mid-transaction (REQ or WAIT): IDLE next cycle, dreq_valid=0, the pending result is discarded, and a late data_ok is ignored.

Test Plan:
- ALU passthrough: in_addr=0x1234, memread=memwrite=0 → one cycle later out_valid=1, out_result=0x1234, dreq_valid never asserted.
- Signed byte load: addr=0x80000003, msize=0, unsigned=0; addr_ok/data_ok in the first REQ cycle, dresp_data=0x0000_0000_8000_0000 → out_result=0xFFFF_FFFF_FFFF_FF80 at t+2.
- Halfword store: addr=0x80000006, msize=1, wdata=0x1234 → dreq_strobe=0xC0, dreq_data=0x1234_0000_0000_0000, held for 3 cycles of addr_ok=0.
- Split handshake: 32-bit unsigned load at 0x80000004; addr_ok at REQ cycle 1, data_ok 4 cycles later with data 0xFFFF_FFFF_0000_0000 → stall high for 5 cycles, out_result=0x0000_0000_FFFF_FFFF.
- Misaligned: 8B load at 0x80000004 → no dreq_valid; out_valid next cycle, misalign=1, out_regwrite=0.
- Backpressure and reset: out_ready=0 for 3 cycles in DONE → outputs stable, in_ready=0; reset asserted in WAIT → IDLE, dreq_valid=0, a following data_ok produces no out_valid.

Source files
------------

// File: rtl/mem_access.sv
// mem_access: memory stage turning loads/stores into one data-bus request and
// handing aligned, extended results (or passthrough ALU values) to writeback.
module mem_access #(
  parameter int DATA_W      = 64,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic              in_memread,
  input  logic              in_memwrite,
  input  logic [1:0]        in_msize,
  input  logic              in_unsigned,
  input  logic              in_regwrite,
  input  logic              in_memtoreg,
  input  logic [4:0]        in_dst,
  input  logic [DATA_W-1:0] in_pc,
  output logic              dreq_valid,
  output logic [DATA_W-1:0] dreq_addr,
  output logic [1:0]        dreq_size,
  output logic [7:0]        dreq_strobe,
  output logic [DATA_W-1:0] dreq_data,
  input  logic              dresp_addr_ok,
  input  logic              dresp_data_ok,
  input  logic [DATA_W-1:0] dresp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_regwrite,
  output logic              out_memtoreg,
  output logic [4:0]        out_dst,
  output logic [DATA_W-1:0] out_pc,
  output logic              misalign,
  output logic              stall
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic              dreq_valid_q, dreq_valid_d;
  logic [DATA_W-1:0] dreq_addr_q, dreq_addr_d;
  logic [1:0]        dreq_size_q, dreq_size_d;
  logic [7:0]        dreq_strobe_q, dreq_strobe_d;
  logic [DATA_W-1:0] dreq_data_q, dreq_data_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_result_q, out_result_d;
  logic              out_regwrite_q, out_regwrite_d;
  logic              out_memtoreg_q, out_memtoreg_d;
  logic [4:0]        out_dst_q, out_dst_d;
  logic [DATA_W-1:0] out_pc_q, out_pc_d;
  logic              misalign_q, misalign_d;
  logic              ld_q, ld_d;
  logic              uns_q, uns_d;
  logic              capture, is_mem, fault, sx;
  logic [2:0]        align_mask;
  logic [7:0]        lane_mask;
  logic [DATA_W-1:0] raw, ld_val, done_result;
  assign in_ready     = (state_q == IDLE) || (state_q == DONE && out_ready);
  assign capture      = in_valid & in_ready;
  assign is_mem       = in_memread | in_memwrite;
  assign align_mask   = {in_msize == 2'd3, in_msize[1], |in_msize};
  assign fault        = is_mem & ALIGN_CHECK & (|(in_addr[2:0] & align_mask));
  assign lane_mask    = in_msize == 2'd0 ? 8'h01 : in_msize == 2'd1 ? 8'h03 :
                        in_msize == 2'd2 ? 8'h0F : 8'hFF;
  // Extraction uses the held request, so it stays valid across WAIT.
  assign raw          = dresp_data >> {dreq_addr_q[2:0], 3'b000};
  assign sx           = ~uns_q;
  assign ld_val       = dreq_size_q == 2'd0 ? {{56{sx & raw[7]}}, raw[7:0]} :
                        dreq_size_q == 2'd1 ? {{48{sx & raw[15]}}, raw[15:0]} :
                        dreq_size_q == 2'd2 ? {{32{sx & raw[31]}}, raw[31:0]} : raw;
  assign done_result  = ld_q ? ld_val : out_result_q;
  assign stall        = (state_q == REQ) || (state_q == WAIT);
  assign dreq_valid   = dreq_valid_q;
  assign dreq_addr    = dreq_addr_q;
  assign dreq_size    = dreq_size_q;
  assign dreq_strobe  = dreq_strobe_q;
  assign dreq_data    = dreq_data_q;
  assign out_valid    = out_valid_q;
  assign out_result   = out_result_q;
  assign out_regwrite = out_regwrite_q;
  assign out_memtoreg = out_memtoreg_q;
  assign out_dst      = out_dst_q;
  assign out_pc       = out_pc_q;
  assign misalign     = misalign_q;
  always_comb begin
    state_d        = state_q;
    dreq_valid_d   = dreq_valid_q;
    dreq_addr_d    = dreq_addr_q;
    dreq_size_d    = dreq_size_q;
    dreq_strobe_d  = dreq_strobe_q;
    dreq_data_d    = dreq_data_q;
    out_valid_d    = out_valid_q;
    out_result_d   = out_result_q;
    out_regwrite_d = out_regwrite_q;
    out_memtoreg_d = out_memtoreg_q;
    out_dst_d      = out_dst_q;
    out_pc_d       = out_pc_q;
    misalign_d     = misalign_q;
    ld_d           = ld_q;
    uns_d          = uns_q;
    unique case (state_q)
      REQ: if (dresp_addr_ok) begin
        dreq_valid_d = 1'b0;
        state_d      = dresp_data_ok ? DONE : WAIT;
        out_valid_d  = dresp_data_ok;
        out_result_d = dresp_data_ok ? done_result : out_result_q;
      end
      WAIT: if (dresp_data_ok) begin
        state_d      = DONE;
        out_valid_d  = 1'b1;
        out_result_d = done_result;
      end
      DONE: if (out_ready) begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
      default: ;
    endcase
    if (capture) begin
      out_result_d   = in_addr;
      out_regwrite_d = in_regwrite & ~fault;
      out_memtoreg_d = in_memtoreg;
      out_dst_d      = in_dst;
      out_pc_d       = in_pc;
      misalign_d     = fault;
      ld_d           = in_memread & ~fault;
      uns_d          = in_unsigned;
      state_d        = (is_mem & ~fault) ? REQ : DONE;
      out_valid_d    = ~(is_mem & ~fault);
      dreq_valid_d   = is_mem & ~fault;
      if (is_mem & ~fault) begin
        dreq_addr_d   = in_addr;
        dreq_size_d   = in_msize;
        dreq_strobe_d = in_memwrite ? 8'(lane_mask << in_addr[2:0]) : 8'h00;
        dreq_data_d   = in_wdata << {in_addr[2:0], 3'b000};
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      dreq_valid_q   <= 1'b0;
      dreq_addr_q    <= '0;
      dreq_size_q    <= '0;
      dreq_strobe_q  <= '0;
      dreq_data_q    <= '0;
      out_valid_q    <= 1'b0;
      out_result_q   <= '0;
      out_regwrite_q <= 1'b0;
      out_memtoreg_q <= 1'b0;
      out_dst_q      <= '0;
      out_pc_q       <= '0;
      misalign_q     <= 1'b0;
      ld_q           <= 1'b0;
      uns_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      dreq_valid_q   <= dreq_valid_d;
      dreq_addr_q    <= dreq_addr_d;
      dreq_size_q    <= dreq_size_d;
      dreq_strobe_q  <= dreq_strobe_d;
      dreq_data_q    <= dreq_data_d;
      out_valid_q    <= out_valid_d;
      out_result_q   <= out_result_d;
      out_regwrite_q <= out_regwrite_d;
      out_memtoreg_q <= out_memtoreg_d;
      out_dst_q      <= out_dst_d;
      out_pc_q       <= out_pc_d;
      misalign_q     <= misalign_d;
      ld_q           <= ld_d;
      uns_q          <= uns_d;
    end
  end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed and randomized checks of mem_access against a
// behavioural model of addressing, lane placement and load extension.
module tb_mem_access;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [63:0] in_addr = '0, in_wdata = '0, in_pc = '0;
  logic        in_memread = 1'b0, in_memwrite = 1'b0, in_unsigned = 1'b0;
  logic        in_regwrite = 1'b0, in_memtoreg = 1'b0;
  logic [1:0]  in_msize = '0;
  logic [4:0]  in_dst = '0;
  logic        dreq_valid;
  logic [63:0] dreq_addr, dreq_data;
  logic [1:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic        dresp_addr_ok = 1'b0, dresp_data_ok = 1'b0;
  logic [63:0] dresp_data = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [63:0] out_result, out_pc;
  logic        out_regwrite, out_memtoreg, misalign, stall;
  logic [4:0]  out_dst;
  int checks = 0, failures = 0;

  mem_access #(.DATA_W(64), .ALIGN_CHECK(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_memread(in_memread),
    .in_memwrite(in_memwrite), .in_msize(in_msize), .in_unsigned(in_unsigned),
    .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg), .in_dst(in_dst),
    .in_pc(in_pc), .dreq_valid(dreq_valid), .dreq_addr(dreq_addr),
    .dreq_size(dreq_size), .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
    .dresp_data(dresp_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_regwrite(out_regwrite),
    .out_memtoreg(out_memtoreg), .out_dst(out_dst), .out_pc(out_pc),
    .misalign(misalign), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [63:0] ld_model(logic [63:0] line, int off, int nb, bit uns);
    logic [63:0] v = line >> (8 * off);
    logic [63:0] m;
    if (nb == 8) return v;
    m = (64'd1 << (8 * nb)) - 64'd1;
    v = v & m;
    if (!uns && v[8*nb-1]) v = v | ~m;
    return v;
  endfunction

  task automatic do_op(input logic [63:0] a, input logic [63:0] wd, input logic [63:0] line,
                       input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                       input bit rw, input bit m2r, input logic [4:0] dst,
                       input logic [63:0] pc, input int aok, input int dok, input int bp);
    int nb = 1 << sz;
    int off = int'(a[2:0]);
    bit mem = rd | wr;
    bit flt = mem && (a % 64'(nb) != 0);
    logic [15:0] s = ((16'd1 << nb) - 16'd1) << off;
    logic [7:0] exp_strobe = wr ? s[7:0] : 8'h00;
    logic [63:0] exp_data = wd << (8 * off);
    logic [63:0] exp_res = (mem && !flt && rd) ? ld_model(line, off, nb, uns) : a;
    in_valid = 1'b1; in_addr = a; in_wdata = wd; in_memread = rd; in_memwrite = wr;
    in_msize = sz; in_unsigned = uns; in_regwrite = rw; in_memtoreg = m2r;
    in_dst = dst; in_pc = pc; out_ready = 1'b0;
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
    #1 chk("in_ready_idle", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0; in_addr = {$urandom, $urandom}; in_wdata = {$urandom, $urandom};
    in_pc = {$urandom, $urandom};
    if (mem && !flt) begin
      for (int k = 0; k <= aok; k++) begin
        chk("dreq_valid", 64'(dreq_valid), 64'd1);
        chk("dreq_addr", dreq_addr, a);
        chk("dreq_size", 64'(dreq_size), 64'(sz));
        chk("dreq_strobe", 64'(dreq_strobe), 64'(exp_strobe));
        if (wr) chk("dreq_data", dreq_data, exp_data);
        chk("stall_req", 64'(stall), 64'd1);
        chk("out_valid_busy", 64'(out_valid), 64'd0);
        dresp_addr_ok = (k == aok);
        dresp_data_ok = (k == aok) && (dok == 0);
        dresp_data = dresp_data_ok ? line : {$urandom, $urandom};
        step();
      end
      dresp_addr_ok = 1'b0;
      for (int k = 1; k <= dok; k++) begin
        chk("dreq_valid_wait", 64'(dreq_valid), 64'd0);
        chk("stall_wait", 64'(stall), 64'd1);
        dresp_data_ok = (k == dok);
        dresp_data = dresp_data_ok ? line : {$urandom, $urandom};
        step();
      end
      dresp_data_ok = 1'b0;
    end
    chk("out_valid", 64'(out_valid), 64'd1);
    chk("out_result", out_result, exp_res);
    chk("misalign", 64'(misalign), 64'(flt));
    chk("out_regwrite", 64'(out_regwrite), 64'(rw & ~flt));
    chk("out_memtoreg", 64'(out_memtoreg), 64'(m2r));
    chk("out_dst", 64'(out_dst), 64'(dst));
    chk("out_pc", out_pc, pc);
    chk("stall_done", 64'(stall), 64'd0);
    chk("dreq_valid_done", 64'(dreq_valid), 64'd0);
    for (int k = 0; k < bp; k++) begin
      chk("in_ready_bp", 64'(in_ready), 64'd0);
      dresp_data_ok = 1'b1;
      dresp_data = {$urandom, $urandom};
      step();
      chk("out_valid_bp", 64'(out_valid), 64'd1);
      chk("out_result_bp", out_result, exp_res);
      chk("out_dst_bp", 64'(out_dst), 64'(dst));
    end
    dresp_data_ok = 1'b0;
    out_ready = 1'b1;
    #1 chk("in_ready_done", 64'(in_ready), 64'd1);
    step();
    out_ready = 1'b0;
    chk("out_valid_idle", 64'(out_valid), 64'd0);
    chk("stall_idle", 64'(stall), 64'd0);
  endtask

  initial begin
    step(); step();
    reset = 1'b0;
    chk("rst_dreq_valid", 64'(dreq_valid), 64'd0);
    chk("rst_dreq_strobe", 64'(dreq_strobe), 64'd0);
    chk("rst_dreq_addr", dreq_addr, 64'd0);
    chk("rst_dreq_data", dreq_data, 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_misalign", 64'(misalign), 64'd0);
    chk("rst_out_result", out_result, 64'd0);
    chk("rst_out_regwrite", 64'(out_regwrite), 64'd0);
    chk("rst_out_dst", 64'(out_dst), 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    // data_ok while idle must not produce a result
    dresp_data_ok = 1'b1; step(); dresp_data_ok = 1'b0;
    chk("idle_data_ok", 64'(out_valid), 64'd0);
    // ALU passthrough
    do_op(64'h1234, 0, 0, 0, 0, 2'd3, 0, 1, 0, 5'd7, 64'h100, 0, 0, 0);
    // signed byte load
    do_op(64'h8000_0003, 0, 64'h0000_0000_8000_0000, 1, 0, 2'd0, 0, 1, 1, 5'd3, 64'h104, 0, 0, 0);
    // halfword store held through 3 cycles without addr_ok
    do_op(64'h8000_0006, 64'h1234, 0, 0, 1, 2'd1, 0, 0, 0, 5'd0, 64'h108, 3, 0, 0);
    // split handshake, 32-bit unsigned load
    do_op(64'h8000_0004, 0, 64'hFFFF_FFFF_0000_0000, 1, 0, 2'd2, 1, 1, 1, 5'd9, 64'h10C, 0, 4, 0);
    // misaligned doubleword load
    do_op(64'h8000_0004, 0, 0, 1, 0, 2'd3, 0, 1, 1, 5'd4, 64'h110, 0, 0, 0);
    // backpressure in DONE
    do_op(64'hABCD, 0, 0, 0, 0, 2'd0, 0, 1, 0, 5'd12, 64'h114, 0, 0, 3);
    // back-to-back capture while handing off a result
    in_valid = 1'b1; in_memread = 0; in_memwrite = 0; in_addr = 64'h1111; in_dst = 5'd1;
    step();
    in_addr = 64'h2222; in_dst = 5'd2; out_ready = 1'b1;
    #1 chk("b2b_in_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    chk("b2b_out_valid", 64'(out_valid), 64'd1);
    chk("b2b_out_result", out_result, 64'h2222);
    chk("b2b_out_dst", 64'(out_dst), 64'd2);
    step();
    out_ready = 1'b0;
    chk("b2b_idle", 64'(out_valid), 64'd0);
    // reset during WAIT discards the transaction
    in_valid = 1'b1; in_memread = 1; in_msize = 2'd3; in_addr = 64'h8000_0000;
    step();
    in_valid = 1'b0; dresp_addr_ok = 1'b1;
    step();
    dresp_addr_ok = 1'b0;
    chk("wait_stall", 64'(stall), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_dreq_valid", 64'(dreq_valid), 64'd0);
    chk("mid_rst_stall", 64'(stall), 64'd0);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    dresp_data_ok = 1'b1; dresp_data = 64'h55;
    step();
    dresp_data_ok = 1'b0;
    chk("late_data_ok", 64'(out_valid), 64'd0);
    step();
    chk("late_data_ok2", 64'(out_valid), 64'd0);
    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      int kind = $urandom_range(0, 2);
      logic [1:0] sz = 2'($urandom_range(0, 3));
      logic [63:0] a = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
      do_op(a, {$urandom, $urandom}, {$urandom, $urandom}, kind == 1, kind == 2, sz,
            1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), {$urandom, $urandom},
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
